// File: rtl/wb_stage.sv
// ============================================================================
// Module  : wb_stage
// Brief   : Writeback stage; selects the result source, completes loads and
//           drives the register file write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned RETIRE_W     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_reg_write,
  input  logic [4:0]          in_rd,
  input  logic [1:0]          in_wb_sel,
  input  logic [31:0]         in_alu,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_csr,
  input  logic [2:0]          in_funct3,
  input  logic [1:0]          in_byte_off,
  input  logic                dmem_rvalid,
  input  logic [31:0]         dmem_rdata,
  output logic                we,
  output logic [4:0]          wb_addr,
  output logic [31:0]         wb_data,
  output logic                pend_valid,
  output logic [4:0]          pend_rd,
  output logic                load_err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0]  c_SEL_ALU  = 2'd0;
  localparam logic [1:0]  c_SEL_MEM  = 2'd1;
  localparam logic [1:0]  c_SEL_PC4  = 2'd2;
  localparam logic [31:0] c_TMO_LAST = 32'(LOAD_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_reg_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_byte_off;
  logic [31:0] r_tmo_cnt;

  logic        w_xfer;
  logic        w_is_mem;
  logic [31:0] w_src_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_load_bad;
  logic        w_tmo_hit;

  assign in_ready = (r_state == S_IDLE);
  assign w_xfer   = in_valid & in_ready;
  assign w_is_mem = (in_wb_sel == c_SEL_MEM);

  always_comb begin
    w_src_data = in_csr;
    case (in_wb_sel)
      c_SEL_ALU: w_src_data = in_alu;
      c_SEL_PC4: w_src_data = in_pc + 32'd4;
      default:   w_src_data = in_csr;
    endcase
  end

  // Lane extraction uses the offset latched at acceptance, not the live input.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_byte_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half      = r_byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load_data = dmem_rdata;
    w_load_bad  = 1'b0;
    case (r_funct3)
      3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001: begin
        w_load_data = {{16{w_half[15]}}, w_half};
        w_load_bad  = r_byte_off[0];
      end
      3'b010: begin
        w_load_data = dmem_rdata;
        w_load_bad  = (r_byte_off != 2'd0);
      end
      3'b100: w_load_data = {24'd0, w_byte};
      3'b101: begin
        w_load_data = {16'd0, w_half};
        w_load_bad  = r_byte_off[0];
      end
      default: w_load_bad = 1'b1;
    endcase
  end

  // A response arriving in the final allowed cycle takes priority.
  assign w_tmo_hit = (LOAD_TIMEOUT != 0) && !dmem_rvalid && (r_tmo_cnt == c_TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_xfer && w_is_mem) w_state_nxt = S_WAIT_LOAD;
      S_WAIT_LOAD: if (dmem_rvalid || w_tmo_hit) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we          <= 1'b0;
      wb_addr     <= 5'd0;
      wb_data     <= 32'd0;
      pend_valid  <= 1'b0;
      pend_rd     <= 5'd0;
      load_err    <= 1'b0;
      retire_cnt  <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= 3'd0;
      r_byte_off  <= 2'd0;
      r_tmo_cnt   <= 32'd0;
    end else begin
      we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_is_mem) begin
              r_reg_write <= in_reg_write;
              r_funct3    <= in_funct3;
              r_byte_off  <= in_byte_off;
              pend_valid  <= 1'b1;
              pend_rd     <= in_rd;
              r_tmo_cnt   <= 32'd0;
            end else begin
              we         <= in_reg_write & (in_rd != 5'd0);
              wb_addr    <= in_rd;
              wb_data    <= w_src_data;
              retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
          end
        end
        S_WAIT_LOAD: begin
          if (dmem_rvalid) begin
            pend_valid <= 1'b0;
            retire_cnt <= retire_cnt + RETIRE_W'(1);
            if (w_load_bad) begin
              load_err <= 1'b1;
            end else begin
              we      <= r_reg_write & (pend_rd != 5'd0);
              wb_addr <= pend_rd;
              wb_data <= w_load_data;
            end
          end else if (w_tmo_hit) begin
            pend_valid <= 1'b0;
            load_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module  : tb_wb_stage
// Brief   : Directed self-checking bench for wb_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc;
  logic [31:0] in_csr;
  logic [2:0]  in_funct3;
  logic [1:0]  in_byte_off;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_err;
  logic [63:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage #(.LOAD_TIMEOUT(16), .RETIRE_W(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_pc(in_pc),
    .in_csr(in_csr), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .we(we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .load_err(load_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    in_valid = 1'b1; in_wb_sel = 2'd1; in_reg_write = 1'b1;
    in_rd = rd; in_funct3 = f3; in_byte_off = off;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = 5'd0;
    in_wb_sel = 2'd0; in_alu = '0; in_pc = '0; in_csr = '0; in_funct3 = '0;
    in_byte_off = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(wb_addr), 64'd0);
    chk("rst_data", 64'(wb_data), 64'd0);
    chk("rst_pend", 64'(pend_valid), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Back-to-back ALU results, last one targets x0
    in_valid = 1'b1; in_wb_sel = 2'd0; in_reg_write = 1'b1;
    in_rd = 5'd1; in_alu = 32'h11;
    tick();
    chk("alu1_we", 64'(we), 64'd1);
    chk("alu1_addr", 64'(wb_addr), 64'd1);
    chk("alu1_data", 64'(wb_data), 64'h11);
    in_rd = 5'd2; in_alu = 32'h22;
    tick();
    chk("alu2_we", 64'(we), 64'd1);
    chk("alu2_addr", 64'(wb_addr), 64'd2);
    chk("alu2_data", 64'(wb_data), 64'h22);
    in_rd = 5'd0; in_alu = 32'h33;
    tick();
    chk("alu3_we_x0", 64'(we), 64'd0);
    chk("alu3_retire", retire_cnt, 64'd3);
    in_valid = 1'b0;
    tick();
    chk("idle_we", 64'(we), 64'd0);

    // PC+4 wrap and CSR source
    in_valid = 1'b1; in_wb_sel = 2'd2; in_rd = 5'd3; in_pc = 32'hFFFF_FFFC;
    tick();
    chk("pc4_we", 64'(we), 64'd1);
    chk("pc4_data", 64'(wb_data), 64'h0);
    in_wb_sel = 2'd3; in_rd = 5'd31; in_csr = 32'hDEAD_BEEF;
    tick();
    chk("csr_addr", 64'(wb_addr), 64'd31);
    chk("csr_data", 64'(wb_data), 64'hDEAD_BEEF);
    chk("csr_retire", retire_cnt, 64'd5);
    in_valid = 1'b0;

    // LB rd=5 byte 3, response on second wait cycle
    offer_load(5'd5, 3'b000, 2'd3);
    chk("lb_pend", 64'(pend_valid), 64'd1);
    chk("lb_pend_rd", 64'(pend_rd), 64'd5);
    chk("lb_ready", 64'(in_ready), 64'd0);
    chk("lb_wait_we", 64'(we), 64'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_we", 64'(we), 64'd1);
    chk("lb_addr", 64'(wb_addr), 64'd5);
    chk("lb_data", 64'(wb_data), 64'hFFFF_FF80);
    chk("lb_pend_clr", 64'(pend_valid), 64'd0);
    chk("lb_retire", retire_cnt, 64'd6);

    // LHU upper half
    offer_load(5'd6, 3'b101, 2'd2);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h9ABC_1234;
    tick();
    dmem_rvalid = 1'b0;
    chk("lhu_we", 64'(we), 64'd1);
    chk("lhu_data", 64'(wb_data), 64'h0000_9ABC);

    // Misaligned LW
    offer_load(5'd8, 3'b010, 2'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    chk("lwmis_err", 64'(load_err), 64'd1);
    chk("lwmis_we", 64'(we), 64'd0);
    chk("lwmis_retire", retire_cnt, 64'd8);
    chk("lwmis_pend", 64'(pend_valid), 64'd0);

    // Asynchronous reset in the middle of a load to x7
    do_reset();
    offer_load(5'd7, 3'b010, 2'd0);
    chk("mid_pend", 64'(pend_valid), 64'd1);
    chk("mid_pend_rd", 64'(pend_rd), 64'd7);
    #2 reset = 1'b1;
    #1;
    chk("async_pend", 64'(pend_valid), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd1);
    chk("async_retire", retire_cnt, 64'd0);
    chk("async_err", 64'(load_err), 64'd0);
    tick();
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    chk("post_rst_we", 64'(we), 64'd0);
    chk("post_rst_retire", retire_cnt, 64'd0);

    // Timeout: 16 wait cycles without a response
    offer_load(5'd9, 3'b010, 2'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_pre_pend", 64'(pend_valid), 64'd1);
    chk("tmo_pre_err", 64'(load_err), 64'd0);
    tick();
    chk("tmo_err", 64'(load_err), 64'd1);
    chk("tmo_pend", 64'(pend_valid), 64'd0);
    chk("tmo_ready", 64'(in_ready), 64'd1);
    chk("tmo_we", 64'(we), 64'd0);
    chk("tmo_retire", retire_cnt, 64'd0);

    // Response in the 16th wait cycle beats the timeout
    do_reset();
    offer_load(5'd9, 3'b010, 2'd0);
    for (int i = 0; i < 15; i++) tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_we", 64'(we), 64'd1);
    chk("late_addr", 64'(wb_addr), 64'd9);
    chk("late_data", 64'(wb_data), 64'hCAFE_BABE);
    chk("late_err", 64'(load_err), 64'd0);
    chk("late_retire", retire_cnt, 64'd1);
    tick();
    chk("late_we_pulse", 64'(we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage and the producer side of the register file write port; it drives we / wb_addr / wb_data.
- Accepts one retiring instruction per handshake from the memory stage.
- Selects the writeback source: ALU, load, PC+4 or CSR. For loads it waits for the data-memory response, then aligns and extends the data.
- Exposes the pending load destination to decode hazard logic and counts retired instructions.

Parameters:
- LOAD_TIMEOUT, 16: cycles allowed in WAIT_LOAD before abort; 0 disables the timeout.
- RETIRE_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  retiring instruction offered.
- in_ready  out  1  stage can accept; equals (state==IDLE), combinational.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wb_sel  in  2  source select: 0 ALU, 1 MEM, 2 PC+4, 3 CSR.
- in_alu  in  32  ALU result.
- in_pc  in  32  instruction PC.
- in_csr  in  32  CSR read data.
- in_funct3  in  3  load type.
- in_byte_off  in  2  load address[1:0].
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  32  load response word.
- we  out  1  register file write enable (registered).
- wb_addr  out  5  register file write address (registered).
- wb_data  out  32  register file write data (registered).
- pend_valid  out  1  load outstanding.
- pend_rd  out  5  rd of the outstanding load.
- load_err  out  1  sticky error flag: misaligned, illegal funct3 or timeout.
- retire_cnt  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset (async, immediate): state=IDLE; we=0, wb_addr=0, wb_data=0; pend_valid=0, pend_rd=0; load_err=0; retire_cnt=0; timeout counter=0. Reset mid-load drops the load with no write.
- States: IDLE, WAIT_LOAD. A transfer occurs when in_valid & in_ready.
- IDLE, transfer, in_wb_sel!=MEM:
  - Next edge: we = in_reg_write & (in_rd!=0); wb_addr = in_rd.
  - wb_data = in_alu / in_pc+4 (mod 2^32) / in_csr.
  - retire_cnt += 1. Latency 1 cycle; throughput 1 per cycle.
- IDLE, transfer, in_wb_sel==MEM:
  - Latch rd, reg_write, funct3, byte_off; go to WAIT_LOAD.
  - pend_valid=1 and pend_rd=rd from the next cycle. we=0 that cycle.
- IDLE, no transfer: we=0 next cycle; wb_addr/wb_data hold their last values.
- WAIT_LOAD:
  - dmem_rvalid is ignored in IDLE; the earliest response is the cycle after acceptance.
  - On dmem_rvalid: extract per funct3. LB/LBU use byte byte_off. LH/LHU use the halfword at byte_off[1]. LW uses the full word.
  - Sign-extend for funct3 000/001; zero-extend for 100/101.
  - Next edge: we = reg_write & (rd!=0), wb_addr=rd, wb_data=result; retire_cnt += 1; pend_valid=0; state=IDLE.
  - Error response: if the load is misaligned (LH/LHU with byte_off[0]=1, or LW with byte_off!=0) or funct3 is 011/110/111:
    - Set load_err; we=0.
    - retire_cnt still +1.
    - Return to IDLE and clear pend_valid.
  - Timeout counter increments each WAIT_LOAD cycle without dmem_rvalid. If LOAD_TIMEOUT!=0 and the count reaches LOAD_TIMEOUT:
    - Set load_err; we=0; retire_cnt unchanged.
    - Return to IDLE and clear pend_valid.
    - A dmem_rvalid in the timeout cycle wins over the timeout.
  - in_ready=0 throughout. There is one bubble minimum: no accept in the cycle dmem_rvalid is seen.
- General rules:
  - rd==0 never asserts we.
  - we is a single-cycle pulse per instruction.
  - retire_cnt wraps modulo 2^RETIRE_W.
  - load_err clears only on reset.

Test Plan:
- Reset mid-WAIT_LOAD (rd=7) -> we=0, pend_valid=0, state IDLE, retire_cnt=0 immediately; no later write of x7.
- Back-to-back ALU ops rd=1 alu=0x11, rd=2 alu=0x22, rd=0 alu=0x33 on consecutive cycles -> we pulses 1,1,0 one cycle later with wb_addr/wb_data 1/0x11, 2/0x22; retire_cnt=3.
- LB rd=5 byte_off=3, dmem_rdata=0x80FF_0000 returned 2 cycles later -> pend_valid=1, pend_rd=5 while waiting; then we=1, wb_addr=5, wb_data=0xFFFF_FF80.
- LHU byte_off=2, rdata=0x9ABC_1234 -> wb_data=0x0000_9ABC.
- LW byte_off=1 -> load_err=1, no write.
- PC+4 select with in_pc=0xFFFF_FFFC -> wb_data=0x0000_0000. CSR select in_csr=0xDEAD_BEEF, rd=31 -> wb_data=0xDEAD_BEEF.
- LOAD_TIMEOUT=16, LW accepted, no dmem_rvalid -> after 16 wait cycles load_err=1, state IDLE, pend_valid=0, retire_cnt unchanged. Repeat with rvalid on cycle 16 -> normal write, load_err=0.
